vermicom_tx_arbiter: RTL and testbench
======================================

VERMICOM_TX_ARBITER -- requirements
Module: vermicom_tx_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of byte requesters (2..8).
REQ-002 Parameter: DIVISION_INIT, default 868, value written to the divisor register after reset.
REQ-003 Port: clk  in  1  single clock; all state on rising edge.
REQ-004 Port: reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Port: req_valid  in  N_REQ  requester i has a byte pending.
REQ-006 Port: req_data  in  N_REQ x 8  byte of requester i.
REQ-007 Port: req_ready  out  N_REQ  one-hot accept pulse; byte captured this cycle.
REQ-008 Port: dev_valid  out  1  device register access in progress.
REQ-009 Port: dev_write  out  1  1 = write, 0 = read.
REQ-010 Port: dev_address  out  LOCAL_ADDRESS_WIDTH  UART local register index (control, status, division, data).
REQ-011 Port: dev_wdata  out  32  write data.
REQ-012 Port: dev_rdata  in  32  read data, valid when dev_valid && dev_ready.
REQ-013 Port: dev_ready  in  1  access completes in the cycle dev_valid && dev_ready.
REQ-014 Port: busy  out  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have states INIT_DIV, INIT_CTRL, IDLE, WRITE_DATA, POLL_STATUS, CLEAR_STATUS.
REQ-016 INIT_DIV SHALL write DIVISION_INIT to the division address, then go to INIT_CTRL on completion.
REQ-017 INIT_CTRL SHALL write 0 to the control address (both IRQ enables off), then go to IDLE on completion.
REQ-018 In IDLE with any req_valid set, the block SHALL select one winner combinationally.
  - It SHALL assert req_ready of the winner only, in the same cycle.
  - It SHALL capture req_data of the winner into an 8-bit register.
  - It SHALL enter WRITE_DATA on the next edge.
REQ-019 Arbitration SHALL be round-robin: the search starts at (last_grant+1) mod N_REQ; last_grant resets to N_REQ-1, so requester 0 wins first.
REQ-020 req_ready SHALL be all-zero in every state other than IDLE.
REQ-021 WRITE_DATA SHALL write {24'b0, captured byte} to the data address, then go to POLL_STATUS on completion.
REQ-022 POLL_STATUS SHALL read the status address repeatedly until tx_event_flag (bit 1) is 1.
  - Each read is a separate access, with dev_valid held high back-to-back.
  - When a completed read has bit 1 = 1, the FSM goes to CLEAR_STATUS.
REQ-023 CLEAR_STATUS SHALL write {30'b0, 1'b0, rx bit as last read} to the status address, then return to IDLE on completion.
REQ-024 While dev_valid is high and dev_ready is low, dev_write, dev_address and dev_wdata SHALL hold stable.
REQ-025 dev_valid SHALL be registered and high in every non-IDLE state.
REQ-026 Minimum latency from a completed CLEAR_STATUS write to the next grant SHALL be 1 cycle (the IDLE cycle).
REQ-027 req_valid changes outside IDLE SHALL be ignored; a requester dropping req_valid before its grant loses nothing.

Reset
REQ-028 On reset_n low, regardless of state, the block SHALL immediately force:
  - state to INIT_DIV, last_grant to N_REQ-1, captured byte to 0;
  - req_ready = 0, dev_valid = 0, dev_write = 0, dev_address = 0, dev_wdata = 0, busy = 1.
REQ-029 After reset_n rises, dev_valid SHALL assert on the first clock edge.
REQ-030 A transfer cut off by reset SHALL be abandoned and not retried.

Structure
REQ-031 The FSM state enum SHALL go in the shared UART package, alongside the existing local-address enum and control/status structs.
REQ-032 Bit positions SHALL come from those structs, not literals.
REQ-033 A round-robin arbiter sub-module, rr_arbiter, SHALL be used.
  - Inputs: request vector and last_grant.
  - Outputs: one-hot grant and its index.

Verification
REQ-034 Reset, dev_ready tied 1 -> write 868 to division, then write 0 to control, then IDLE; busy falls on cycle 3.
REQ-035 req_valid=0001, data 0x41; status reads return 0,0,2 -> data write 0x41, three status reads, status write 0x0, IDLE.
REQ-036 req_valid=1111 held -> grants in order 0,1,2,3,0; exactly one req_ready per byte.
REQ-037 dev_ready low for 5 cycles on the data write -> address and wdata stable throughout; one write only.
REQ-038 Status read returns 3 (rx flag set) -> clear write is 0x1, preserving rx.
REQ-039 reset_n low during POLL_STATUS -> outputs zero immediately; after release, the init sequence repeats from the division write.

Source files
------------

// File: rtl/vermicom_tx_arbiter_pkg.sv
// Shared UART register-map types: local register indices, control/status layouts
// and the TX arbiter FSM state encoding.
package vermicom_tx_arbiter_pkg;

    localparam int LOCAL_ADDRESS_WIDTH = 2;

    typedef enum logic [LOCAL_ADDRESS_WIDTH-1:0] {
        ADDR_CONTROL  = 2'd0,
        ADDR_STATUS   = 2'd1,
        ADDR_DIVISION = 2'd2,
        ADDR_DATA     = 2'd3
    } local_address_e;

    typedef struct packed {
        logic [29:0] reserved;
        logic        tx_irq_en;
        logic        rx_irq_en;
    } control_t;

    typedef struct packed {
        logic [29:0] reserved;
        logic        tx_event_flag;
        logic        rx_event_flag;
    } status_t;

    typedef enum logic [2:0] {
        ST_INIT_DIV,
        ST_INIT_CTRL,
        ST_IDLE,
        ST_WRITE_DATA,
        ST_POLL_STATUS,
        ST_CLEAR_STATUS
    } tx_state_e;

endpackage

// File: rtl/vermicom_tx_arbiter_rr_arbiter.sv
// Round-robin pick among pending requests, search starting just after last_grant.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % N_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/vermicom_tx_arbiter.sv
// Arbitrates byte requesters onto a UART register port: init divisor/control, then per byte write data, poll TX flag, clear it.
// Latency: grant in the IDLE cycle, data write issued the next edge; at least one IDLE cycle between bytes.
// Backpressure: each register access is held until dev_ready; requesters are accepted only in IDLE via a one-hot req_ready.
module vermicom_tx_arbiter
    import vermicom_tx_arbiter_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int DIVISION_INIT = 868
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ-1:0][7:0]          req_data,
    output logic [N_REQ-1:0]               req_ready,
    output logic                           dev_valid,
    output logic                           dev_write,
    output logic [LOCAL_ADDRESS_WIDTH-1:0] dev_address,
    output logic [31:0]                    dev_wdata,
    input  logic [31:0]                    dev_rdata,
    input  logic                           dev_ready,
    output logic                           busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    tx_state_e        state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_idx;
    logic [N_REQ-1:0] grant;
    logic [7:0]       tx_byte;
    logic [31:0]      wdata_q;
    logic             done;
    status_t          rd_status;
    status_t          clear_word;
    control_t         ctrl_word;
    logic             unused_rdata;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign done         = dev_valid && dev_ready;
    assign rd_status    = status_t'(dev_rdata);
    assign unused_rdata = ^rd_status.reserved;
    assign ctrl_word    = '0;
    assign busy         = (state != ST_IDLE);
    assign req_ready    = (state == ST_IDLE) ? grant : '0;
    // The captured byte is presented straight from its register while the data write is in flight.
    assign dev_wdata    = (state == ST_WRITE_DATA) ? {24'h0, tx_byte} : wdata_q;

    // Clear only the TX event; echo back the RX flag so a pending RX event is not lost.
    always_comb begin
        clear_word               = '0;
        clear_word.rx_event_flag = rd_status.rx_event_flag;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_INIT_DIV;
            last_grant  <= IDX_W'(N_REQ - 1);
            tx_byte     <= '0;
            dev_valid   <= 1'b0;
            dev_write   <= 1'b0;
            dev_address <= '0;
            wdata_q     <= '0;
        end else begin
            case (state)
                ST_INIT_DIV: begin
                    if (!dev_valid) begin
                        dev_valid   <= 1'b1;
                        dev_write   <= 1'b1;
                        dev_address <= ADDR_DIVISION;
                        wdata_q     <= 32'(DIVISION_INIT);
                    end else if (dev_ready) begin
                        state       <= ST_INIT_CTRL;
                        dev_address <= ADDR_CONTROL;
                        wdata_q     <= ctrl_word;
                    end
                end
                ST_INIT_CTRL: begin
                    if (done) begin
                        state     <= ST_IDLE;
                        dev_valid <= 1'b0;
                        dev_write <= 1'b0;
                        wdata_q   <= '0;
                    end
                end
                ST_IDLE: begin
                    if (|req_valid) begin
                        state       <= ST_WRITE_DATA;
                        last_grant  <= grant_idx;
                        tx_byte     <= req_data[grant_idx];
                        dev_valid   <= 1'b1;
                        dev_write   <= 1'b1;
                        dev_address <= ADDR_DATA;
                    end
                end
                ST_WRITE_DATA: begin
                    if (done) begin
                        state       <= ST_POLL_STATUS;
                        dev_write   <= 1'b0;
                        dev_address <= ADDR_STATUS;
                    end
                end
                ST_POLL_STATUS: begin
                    if (done && rd_status.tx_event_flag) begin
                        state     <= ST_CLEAR_STATUS;
                        dev_write <= 1'b1;
                        wdata_q   <= clear_word;
                    end
                end
                ST_CLEAR_STATUS: begin
                    if (done) begin
                        state     <= ST_IDLE;
                        dev_valid <= 1'b0;
                        dev_write <= 1'b0;
                        wdata_q   <= '0;
                    end
                end
                default: state <= ST_INIT_DIV;
            endcase
        end
    end

endmodule

// File: tb/tb_vermicom_tx_arbiter.sv
// Directed bench for vermicom_tx_arbiter: device port responder plus access/grant logs checked against hand-computed values.
module tb_vermicom_tx_arbiter;
    import vermicom_tx_arbiter_pkg::*;

    logic                           clk = 1'b0;
    logic                           reset_n;
    logic [3:0]                     req_valid;
    logic [3:0][7:0]                req_data;
    logic [3:0]                     req_ready;
    logic                           dev_valid;
    logic                           dev_write;
    logic [LOCAL_ADDRESS_WIDTH-1:0] dev_address;
    logic [31:0]                    dev_wdata;
    logic [31:0]                    dev_rdata;
    logic                           dev_ready;
    logic                           busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit                             w;
        logic [LOCAL_ADDRESS_WIDTH-1:0] a;
        logic [31:0]                    d;
        int                             c;
    } acc_t;

    acc_t        acc_q[$];
    logic [3:0]  gnt_q[$];
    int          gnt_cyc[$];
    logic [31:0] rd_q[$];

    always #5 clk = ~clk;

    vermicom_tx_arbiter #(
        .N_REQ         (4),
        .DIVISION_INIT (868)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .dev_valid   (dev_valid),
        .dev_write   (dev_write),
        .dev_address (dev_address),
        .dev_wdata   (dev_wdata),
        .dev_rdata   (dev_rdata),
        .dev_ready   (dev_ready),
        .busy        (busy)
    );

    // Log every completed access and every grant with its cycle stamp.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dev_valid && dev_ready) begin
            acc_q.push_back('{w: dev_write, a: dev_address, d: dev_wdata, c: cyc});
            if (!dev_write && rd_q.size() > 0) void'(rd_q.pop_front());
        end
        if (req_ready != 4'b0) begin
            gnt_q.push_back(req_ready);
            gnt_cyc.push_back(cyc);
        end
    end

    // Status read data: next queued value, TX flag set once the queue runs dry.
    always @(negedge clk) dev_rdata = (rd_q.size() > 0) ? rd_q[0] : 32'h2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_acc(input string tag, input int i, input bit w,
                           input logic [LOCAL_ADDRESS_WIDTH-1:0] a, input logic [31:0] d);
        if (i < acc_q.size()) begin
            chk({tag, "_write"}, 32'(acc_q[i].w), 32'(w));
            chk({tag, "_addr"}, 32'(acc_q[i].a), 32'(a));
            if (w) chk({tag, "_wdata"}, acc_q[i].d, d);
        end else begin
            chk({tag, "_present"}, acc_q.size(), i + 1);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [3:0] exp_g [5];
        logic [7:0] exp_b [5];
        int n;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

        reset_n   = 1'b1;
        req_valid = '0;
        req_data  = '0;
        dev_ready = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_dev_valid", 32'(dev_valid), 32'd0);
        chk("rst_dev_write", 32'(dev_write), 32'd0);
        chk("rst_dev_address", 32'(dev_address), 32'd0);
        chk("rst_dev_wdata", dev_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_req_ready", 32'(req_ready), 32'd0);

        // Init sequence with dev_ready tied high.
        reset_n = 1'b1;
        @(negedge clk);
        chk("init_div_valid", 32'(dev_valid), 32'd1);
        chk("init_div_addr", 32'(dev_address), 32'd2);
        chk("init_div_wdata", dev_wdata, 32'd868);
        @(negedge clk);
        chk("init_ctrl_addr", 32'(dev_address), 32'd0);
        chk("init_busy_c2", 32'(busy), 32'd1);
        @(negedge clk);
        chk("init_busy_c3", 32'(busy), 32'd0);
        chk("init_idle_valid", 32'(dev_valid), 32'd0);
        chk("init_acc_count", acc_q.size(), 32'd2);
        chk_acc("init_div", 0, 1'b1, 2'd2, 32'd868);
        chk_acc("init_ctrl", 1, 1'b1, 2'd0, 32'd0);
        acc_q.delete();

        // All four requesting: round-robin from requester 0.
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'b1111;
        #1 chk("rr_first_ready", 32'(req_ready), 32'b0001);
        n = 0;
        while (gnt_q.size() < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        req_valid = '0;
        chk("rr_grant_count", gnt_q.size(), 32'd5);
        wait_idle("rr_idle");
        for (int i = 0; i < 5; i++) begin
            if (i < gnt_q.size()) chk($sformatf("rr_grant_%0d", i), 32'(gnt_q[i]), 32'(exp_g[i]));
        end
        if (gnt_cyc.size() > 1) chk("rr_grant_gap", gnt_cyc[1] - gnt_cyc[0], 32'd4);
        chk("rr_acc_count", acc_q.size(), 32'd15);
        for (int i = 0; i < 5; i++) begin
            chk_acc($sformatf("rr_data_%0d", i), i * 3, 1'b1, 2'd3, {24'h0, exp_b[i]});
            chk_acc($sformatf("rr_clear_%0d", i), i * 3 + 2, 1'b1, 2'd1, 32'd0);
        end
        acc_q.delete();
        gnt_q.delete();
        gnt_cyc.delete();

        // Single requester, status reads 0,0,2.
        rd_q.push_back(32'h0);
        rd_q.push_back(32'h0);
        rd_q.push_back(32'h2);
        req_data[0] = 8'h41;
        req_valid   = 4'b0001;
        #1 chk("one_ready", 32'(req_ready), 32'b0001);
        @(negedge clk);
        chk("one_ready_blocked", 32'(req_ready), 32'd0);
        chk("one_data_addr", 32'(dev_address), 32'd3);
        chk("one_data_wdata", dev_wdata, 32'h41);
        req_valid = '0;
        wait_idle("one_idle");
        chk("one_acc_count", acc_q.size(), 32'd5);
        chk_acc("one_data", 0, 1'b1, 2'd3, 32'h41);
        chk_acc("one_rd0", 1, 1'b0, 2'd1, 32'd0);
        chk_acc("one_rd1", 2, 1'b0, 2'd1, 32'd0);
        chk_acc("one_rd2", 3, 1'b0, 2'd1, 32'd0);
        chk_acc("one_clear", 4, 1'b1, 2'd1, 32'h0);
        if (acc_q.size() > 3) chk("one_poll_b2b", acc_q[3].c - acc_q[1].c, 32'd2);
        chk("one_grant_count", gnt_q.size(), 32'd1);
        acc_q.delete();
        gnt_q.delete();

        // Status returns 3: RX flag preserved in the clear write.
        rd_q.push_back(32'h3);
        req_data[2] = 8'h5A;
        req_valid   = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        wait_idle("rx_idle");
        chk("rx_acc_count", acc_q.size(), 32'd3);
        chk_acc("rx_data", 0, 1'b1, 2'd3, 32'h5A);
        chk_acc("rx_clear", 2, 1'b1, 2'd1, 32'h1);
        if (gnt_q.size() > 0) chk("rx_grant", 32'(gnt_q[0]), 32'b0100);
        acc_q.delete();
        gnt_q.delete();

        // Data write stalled: outputs must hold.
        dev_ready   = 1'b0;
        req_data[3] = 8'hC3;
        req_valid   = 4'b1000;
        @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_valid_%0d", i), 32'(dev_valid), 32'd1);
            chk($sformatf("stall_write_%0d", i), 32'(dev_write), 32'd1);
            chk($sformatf("stall_addr_%0d", i), 32'(dev_address), 32'd3);
            chk($sformatf("stall_wdata_%0d", i), dev_wdata, 32'hC3);
            @(negedge clk);
        end
        dev_ready = 1'b1;
        wait_idle("stall_idle");
        chk("stall_acc_count", acc_q.size(), 32'd3);
        chk_acc("stall_data", 0, 1'b1, 2'd3, 32'hC3);
        chk_acc("stall_read", 1, 1'b0, 2'd1, 32'd0);
        acc_q.delete();
        gnt_q.delete();

        // Reset while polling status.
        for (int i = 0; i < 8; i++) rd_q.push_back(32'h0);
        req_data[0] = 8'h77;
        req_valid   = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        chk("poll_valid", 32'(dev_valid), 32'd1);
        chk("poll_write", 32'(dev_write), 32'd0);
        chk("poll_addr", 32'(dev_address), 32'd1);
        acc_q.delete();
        gnt_q.delete();
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(dev_valid), 32'd0);
        chk("mid_rst_write", 32'(dev_write), 32'd0);
        chk("mid_rst_addr", 32'(dev_address), 32'd0);
        chk("mid_rst_wdata", dev_wdata, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd1);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        rd_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rerun_div_valid", 32'(dev_valid), 32'd1);
        chk("rerun_div_addr", 32'(dev_address), 32'd2);
        chk("rerun_div_wdata", dev_wdata, 32'd868);
        wait_idle("rerun_idle");
        repeat (3) @(negedge clk);
        chk("rerun_acc_count", acc_q.size(), 32'd2);
        chk_acc("rerun_div", 0, 1'b1, 2'd2, 32'd868);
        chk_acc("rerun_ctrl", 1, 1'b1, 2'd0, 32'd0);
        chk("rerun_no_grant", gnt_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
